// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift/rotate sequencer driving a shared 1-bit shift stage
// Optional macro SHIFT_SEQ_NIBBLE_EN adds a 4-bit step path for shorter latency.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] cnt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] remaining;

  // Single-bit step of the latched operation; SRA is the fall-through case.
  function automatic logic [WIDTH-1:0] step1(input logic [1:0] o, input logic [WIDTH-1:0] d);
    case (o)
      OP_ROL:  step1 = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_SLL:  step1 = {d[WIDTH-2:0], 1'b0};
      OP_SRL:  step1 = {1'b0, d[WIDTH-1:1]};
      default: step1 = {d[WIDTH-1], d[WIDTH-1:1]};
    endcase
  endfunction

`ifdef SHIFT_SEQ_NIBBLE_EN
  // Four-bit step; same semantics as four consecutive single-bit steps.
  function automatic logic [WIDTH-1:0] step4(input logic [1:0] o, input logic [WIDTH-1:0] d);
    case (o)
      OP_ROL:  step4 = {d[WIDTH-5:0], d[WIDTH-1:WIDTH-4]};
      OP_SLL:  step4 = {d[WIDTH-5:0], 4'b0};
      OP_SRL:  step4 = {4'b0, d[WIDTH-1:4]};
      default: step4 = {{4{d[WIDTH-1]}}, d[WIDTH-1:4]};
    endcase
  endfunction
`endif

  // Handshake flags depend on state alone so the hazard unit sees no input-to-output path.
  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT) || (state == DONE);

  // Sequencer: latch request, step until remaining is exhausted, publish result with a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      op_q      <= '0;
      remaining <= '0;
      done      <= 1'b0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_q    <= in_data;
            op_q      <= op;
            remaining <= cnt;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (remaining == '0) begin
            out_data <= data_q;
            done     <= 1'b1;
            state    <= DONE;
`ifdef SHIFT_SEQ_NIBBLE_EN
          end else if (remaining >= CNT_W'(4)) begin
            data_q    <= step4(op_q, data_q);
            remaining <= remaining - CNT_W'(4);
`endif
          end else begin
            data_q    <= step1(op_q, data_q);
            remaining <= remaining - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] in_data;
  logic [3:0]  cnt;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .in_data  (in_data),
    .cnt      (cnt),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int c);
`ifdef SHIFT_SEQ_NIBBLE_EN
    return c / 4 + c % 4 + 1;
`else
    return c + 1;
`endif
  endfunction

  // One request: accept, optionally poke start while busy, measure latency, check result and single pulse.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] d,
                       input logic [3:0] c, input logic [15:0] exp_d, input bit poke);
    int k;
    @(negedge clk);
    check({tag, ".ready_idle"}, 32'(ready), 32'd1);
    start = 1'b1; op = o; in_data = d; cnt = c;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".ready_low"}, 32'(ready), 32'd0);
    check({tag, ".busy_high"}, 32'(busy), 32'd1);
    if (poke) begin
      start = 1'b1; op = 2'b00; in_data = 16'hFFFF; cnt = 4'd0;
    end else begin
      start = 1'b0; in_data = ~d; op = ~o; cnt = ~c;
    end
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    check({tag, ".latency"}, 32'(k), 32'(exp_lat(int'(c))));
    check({tag, ".out_data"}, 32'(out_data), 32'(exp_d));
    check({tag, ".busy_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".ready_after"}, 32'(ready), 32'd1);
    check({tag, ".out_hold"}, 32'(out_data), 32'(exp_d));
    @(negedge clk);
    check({tag, ".no_requeue"}, 32'({ready, done}), 32'b10);
  endtask

  initial begin
    int prev;
    int ndone;
    bit last_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; in_data = 16'h0; cnt = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.ready", 32'(ready), 32'd1);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.out", 32'(out_data), 32'h0);
    rst = 1'b0;

    do_op("rol1",   2'b00, 16'h8001, 4'd1,  16'h0003, 1'b0);
    do_op("sra15",  2'b11, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
    do_op("srl15",  2'b10, 16'h8000, 4'd15, 16'h0001, 1'b0);
    do_op("sll0",   2'b01, 16'h1234, 4'd0,  16'h1234, 1'b0);
    do_op("sll4",   2'b01, 16'h1234, 4'd4,  16'h2340, 1'b0);
    do_op("sra5",   2'b11, 16'h7F00, 4'd5,  16'h03F8, 1'b0);
    do_op("rol7",   2'b00, 16'hF00D, 4'd7,  16'h06F8, 1'b0);
    do_op("ignore", 2'b01, 16'h0001, 4'd3,  16'h0008, 1'b1);

    // Reset mid-operation discards the result.
    @(negedge clk);
    start = 1'b1; op = 2'b00; in_data = 16'hA5A5; cnt = 4'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.ready", 32'(ready), 32'd1);
    check("rstmid.out", 32'(out_data), 32'h0);
    check("rstmid.done", 32'(done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rstmid.no_done", 32'(ndone), 32'd0);
    do_op("rolA5", 2'b00, 16'hA5A5, 4'd8, 16'hA5A5, 1'b0);

    // Back-to-back with start held high: period of cnt+3 edges per result.
    @(negedge clk);
    start = 1'b1; op = 2'b10; in_data = 16'hFFFF; cnt = 4'd2;
    prev = -1; ndone = 0; last_done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (last_done) check("b2b.ready_gap", 32'(ready), 32'd1);
      last_done = done;
      if (done) begin
        check("b2b.out", 32'(out_data), 32'h3FFF);
        if (prev >= 0) check("b2b.period", 32'(i - prev), 32'd5);
        prev = i;
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b.count", 32'(ndone >= 5), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift/rotate controller for the 16-bit execute-stage datapath.
- Accepts an operation, an operand and a shift amount, then drives a single 1-bit shift/rotate stage once per cycle until the amount is exhausted.
- Returns the result with a done pulse.
- Lets the ALU share one cheap 1-bit shifter instead of a full barrel shifter; the hazard unit stalls on busy.

Parameters:
- WIDTH, 16, data width in bits.
- CNT_W, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk       input   1        system clock, all state updates on rising edge
- rst       input   1        synchronous active-high reset
- start     input   1        request; accepted only when ready=1
- op        input   2        00 ROL, 01 SLL, 10 SRL, 11 SRA
- in_data   input   WIDTH    operand, sampled on the accepting edge
- cnt       input   CNT_W    shift amount 0..WIDTH-1, sampled on the accepting edge
- ready     output  1        high only in IDLE
- busy      output  1        high in SHIFT and DONE
- done      output  1        one-cycle pulse, result valid
- out_data  output  WIDTH    result; held until the next done

Behaviour:
- Reset values: state=IDLE, ready=1, busy=0, done=0, out_data=0, internal data/op/remaining registers=0.
- States:
  - IDLE: on start=1, latch in_data, op and cnt (remaining=cnt), then go to SHIFT. With start=0, stay in IDLE.
  - SHIFT, remaining!=0: apply a 1-bit step of the latched op to the data register; remaining -= 1; stay in SHIFT.
  - SHIFT, remaining==0: out_data <= data register; go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE on the next edge unconditionally.
- 1-bit step semantics:
  - ROL: {d[W-2:0], d[W-1]}
  - SLL: {d[W-2:0], 0}
  - SRL: {0, d[W-1:1]}
  - SRA: {d[W-1], d[W-1:1]}
- Latency: with the accepting edge as edge 0, done is high in the cycle following edge cnt+1. That is 1 cycle for cnt=0 and 16 cycles for cnt=15.
- cnt=0: no steps; out_data equals in_data unchanged.
- start while ready=0: ignored, no queuing. Inputs are not re-sampled mid-operation.
- in_data, op and cnt may change freely after the accepting edge.
- out_data changes only on the edge entering DONE (or on reset). It is stable for the entire IDLE period.
- rst=1 in any state: next edge returns to IDLE with the reset values above. Any in-flight result is discarded and done is not asserted.
- rst and start high together: rst wins, request dropped.
- ready and busy are purely state-decoded, combinational from state only, and never high together.
- No arithmetic wrap on remaining: it decrements only while nonzero.

Optional Feature:
- Macro SHIFT_SEQ_NIBBLE_EN.
- Defined:
  - A second 4-bit step path is added.
  - In SHIFT with remaining>=4, apply a 4-bit step of the latched op and subtract 4.
  - Otherwise use the 1-bit step.
  - Latency becomes floor(cnt/4) + (cnt mod 4) + 1 cycles; cnt=15 gives 7.
  - 4-bit step semantics:
    - ROL: {d[W-5:0], d[W-1:W-4]}
    - SLL: {d[W-5:0], 4'b0}
    - SRL: {4'b0, d[W-1:4]}
    - SRA: {{4{d[W-1]}}, d[W-1:4]}
- Not defined: the 1-bit path only, exactly as above. All results are identical either way; only latency differs.

Test Plan:
- Reset, then ROL in_data=0x8001 cnt=1 -> done 2 cycles after the accepting edge, out_data=0x0003; ready low during SHIFT/DONE, high after.
- SRA in_data=0x8000 cnt=15 -> out_data=0xFFFF, done after exactly 16 cycles (7 with SHIFT_SEQ_NIBBLE_EN); SRL same operand/cnt -> 0x0001.
- SLL in_data=0x1234 cnt=0 -> out_data=0x1234, done 1 cycle after accept. Next, SLL 0x1234 cnt=4 -> 0x2340.
- Pulse start with a different in_data/cnt while busy=1 -> ignored; out_data equals the result of the first request only. A single done pulse is seen.
- Start ROL 0xA5A5 cnt=8, assert rst for 1 cycle at cycle 3 -> IDLE next edge, out_data=0, done never asserted. A fresh ROL 0xA5A5 cnt=8 then completes with 0xA5A5.
- Back-to-back: start held high continuously with SRL 0xFFFF cnt=2 -> results 0x3FFF recur with one idle (ready) cycle between each DONE and the next accept.
